// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline control blocks: forwarding
// select codes, hazard FSM state encoding and the forwarding priority rule.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // A load sitting in EX/MEM has no data yet, so it is never a forward source.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] mem_rd,
    input logic       mem_gprwr,
    input logic       mem_lw,
    input logic [4:0] wb_rd,
    input logic       wb_gprwr
  );
    if (mem_gprwr && !mem_lw && mem_rd != 5'd0 && mem_rd == src)
      return FWD_MEM;
    else if (wb_gprwr && wb_rd != 5'd0 && wb_rd == src)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational ALU operand forwarding selects for both EX source operands.
module fwd_unit
  import mips_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_rd,
  input  logic       mem_gprwr,
  input  logic       mem_lw,
  input  logic [4:0] wb_rd,
  input  logic       wb_gprwr,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_sel(ex_rs, mem_rd, mem_gprwr, mem_lw, wb_rd, wb_gprwr);
  assign fwd_b = fwd_sel(ex_rt, mem_rd, mem_gprwr, mem_lw, wb_rd, wb_gprwr);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait FSM with timeout, load-use
// bubble, branch flush and operand forwarding for the five-stage core.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_lw,
  input  logic [4:0] mem_rd,
  input  logic       mem_gprwr,
  input  logic       mem_lw,
  input  logic       mem_dmwr,
  input  logic [4:0] wb_rd,
  input  logic       wb_gprwr,
  input  logic       branch_taken,
  input  logic       dm_ready,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_stall,
  output logic       exmem_stall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       memwb_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       dm_req,
  output logic       dm_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dm_err_nxt;
  logic          mem_acc, mem_stall, load_use, branch_flush;
  logic [1:0]    fwd_a_raw, fwd_b_raw;

  assign mem_acc = mem_lw | mem_dmwr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the combinational block below uses blocking ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      cnt    <= '0;
      dm_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dm_err <= dm_err_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dm_err_nxt = dm_err;
    mem_stall  = 1'b0;
    dm_req     = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (mem_acc) begin
          dm_req = 1'b1;
          if (!dm_ready) begin
            mem_stall = 1'b1;
            state_nxt = ST_WAIT;
            cnt_nxt   = CW'(1);
          end
        end
      end
      ST_WAIT: begin
        dm_req = 1'b1;
        if (dm_ready) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else if (cnt < CNT_MAX) begin
          mem_stall = 1'b1;
          cnt_nxt   = cnt + CW'(1);
        end else begin
          // Abort: release the pipeline and flag the lost access.
          dm_err_nxt = 1'b1;
          state_nxt  = ST_RUN;
          cnt_nxt    = '0;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if (rst) begin
      dm_req    = 1'b0;
      mem_stall = 1'b0;
    end
  end

  assign load_use = !rst && !mem_stall && ex_lw && ex_rd != 5'd0 &&
                    (ex_rd == id_rs || ex_rd == id_rt);

  // A taken branch lost to a load-use bubble is re-resolved next cycle.
  assign branch_flush = !rst && !mem_stall && !load_use && branch_taken;

  assign pc_stall     = mem_stall | load_use;
  assign ifid_stall   = mem_stall | load_use;
  assign idex_stall   = mem_stall;
  assign exmem_stall  = mem_stall;
  assign memwb_bubble = rst | mem_stall;
  assign idex_flush   = rst | load_use;
  assign ifid_flush   = rst | branch_flush;

  fwd_unit u_fwd (
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .mem_rd    (mem_rd),
    .mem_gprwr (mem_gprwr),
    .mem_lw    (mem_lw),
    .wb_rd     (wb_rd),
    .wb_gprwr  (wb_gprwr),
    .fwd_a     (fwd_a_raw),
    .fwd_b     (fwd_b_raw)
  );

  assign fwd_a = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b = rst ? FWD_RF : fwd_b_raw;

endmodule
